// File: rtl/neurotransmitter_integrator.sv
// Saturating 8-bit level accumulator driven by tick-strobed inc/dec requests.
// Neutral ticks decay the level toward RESET_LEVEL; fast steps start a refractory window.
module neurotransmitter_integrator #(
  parameter logic [7:0] RESET_LEVEL   = 8'h80,
  parameter int         STEP          = 1,
  parameter int         FAST_STEP     = 8,
  parameter int         DECAY_PERIOD  = 16,
  parameter int         REFRACT_TICKS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       inc,
  input  logic       dec,
  input  logic       fast,
  output logic [7:0] level,
  output logic [1:0] level_q,
  output logic       q_changed,
  output logic       at_min,
  output logic       at_max,
  output logic       refractory
);

  typedef enum logic {NORMAL, REFRACT} state_t;

  localparam logic [3:0] DECAY_LAST   = 4'(DECAY_PERIOD - 1);
  localparam logic [3:0] REFRACT_LOAD = 4'(REFRACT_TICKS - 1);

  // Handshake: none; inputs are sampled only on rising clk edges with tick=1,
  // and every output is a register or a pure decode of the level/state registers.

  state_t     state;
  logic [3:0] decay_cnt;
  logic [3:0] refr_cnt;

  logic       raise;
  logic       lower;
  logic       use_fast;
  logic [8:0] step9;
  logic [8:0] sum9;
  logic [8:0] diff9;
  logic [7:0] level_next;

  always_comb begin
    raise      = inc & ~dec;
    lower      = dec & ~inc;
    use_fast   = fast && (state == NORMAL);
    step9      = use_fast ? 9'(FAST_STEP) : 9'(STEP);
    sum9       = {1'b0, level} + step9;
    diff9      = {1'b0, level} - step9;
    level_next = level;
    if (raise) begin
      level_next = sum9[8] ? 8'hFF : sum9[7:0];
    end else if (lower) begin
      // bit 8 of the 9-bit difference is the borrow out of zero
      level_next = diff9[8] ? 8'h00 : diff9[7:0];
    end else if (decay_cnt == DECAY_LAST) begin
      if (level < RESET_LEVEL) begin
        level_next = level + 8'd1;
      end else if (level > RESET_LEVEL) begin
        level_next = level - 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level     <= RESET_LEVEL;
      decay_cnt <= 4'd0;
      refr_cnt  <= 4'd0;
      state     <= NORMAL;
      q_changed <= 1'b0;
    end else if (tick) begin
      level     <= level_next;
      q_changed <= (level_next[7:6] != level[7:6]);
      if (raise || lower || (decay_cnt == DECAY_LAST)) begin
        decay_cnt <= 4'd0;
      end else begin
        decay_cnt <= decay_cnt + 4'd1;
      end
      case (state)
        NORMAL: begin
          // a fast step that saturates still counts as applied
          if ((raise || lower) && use_fast) begin
            state    <= REFRACT;
            refr_cnt <= REFRACT_LOAD;
          end
        end
        REFRACT: begin
          if (refr_cnt == 4'd0) begin
            state <= NORMAL;
          end else begin
            refr_cnt <= refr_cnt - 4'd1;
          end
        end
        default: state <= NORMAL;
      endcase
    end else begin
      q_changed <= 1'b0;
    end
  end

  assign level_q    = level[7:6];
  assign at_min     = (level == 8'h00);
  assign at_max     = (level == 8'hFF);
  assign refractory = (state == REFRACT);

endmodule

// File: doc/neurotransmitter_integrator.md
NEUROTRANSMITTER_INTEGRATOR -- requirements
Module: neurotransmitter_integrator

Interface
REQ-001 SHALL have parameter RESET_LEVEL, default 8'h80, meaning the level after reset and the decay target.
REQ-002 SHALL have parameter STEP, default 1, meaning the level change for a normal inc/dec tick.
REQ-003 SHALL have parameter FAST_STEP, default 8, meaning the level change for a fast inc/dec tick.
REQ-004 SHALL have parameter DECAY_PERIOD, default 16, meaning the number of consecutive neutral ticks per decay step (range 1..16).
REQ-005 SHALL have parameter REFRACT_TICKS, default 4, meaning the number of ticks during which fast is ignored after a fast change (range 1..15).
REQ-006 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-008 SHALL have port tick, input, 1 bit: update strobe; the block changes state only on edges where tick=1.
REQ-009 SHALL have port inc, input, 1 bit: raise request from the upstream regulator.
REQ-010 SHALL have port dec, input, 1 bit: lower request from the upstream regulator.
REQ-011 SHALL have port fast, input, 1 bit: use FAST_STEP instead of STEP.
REQ-012 SHALL have port level, output, 8 bits: registered accumulator value.
REQ-013 SHALL have port level_q, output, 2 bits: equal to level[7:6], the quantised level for the neurotransmitter_level bus.
REQ-014 SHALL have port q_changed, output, 1 bit: one-cycle pulse when level_q takes a new value.
REQ-015 SHALL have port at_min, output, 1 bit: high when level==0.
REQ-016 SHALL have port at_max, output, 1 bit: high when level==255.
REQ-017 SHALL have port refractory, output, 1 bit: high while the FSM is in REFRACT.

Function
REQ-018 SHALL sample inc, dec and fast only on rising clk edges with tick=1; with tick=0 all registers hold and q_changed=0.
REQ-019 SHALL classify each tick as RAISE (inc=1, dec=0), LOWER (dec=1, inc=0) or NEUTRAL (inc=dec, both 0 or both 1).
REQ-020 SHALL use FAST_STEP when fast=1 and the FSM is in NORMAL, and STEP otherwise, including all of REFRACT.
REQ-021 SHALL compute RAISE as min(level+step, 255) and LOWER as max(level-step, 0), using 9-bit intermediates with no wrap-around.
REQ-022 SHALL keep a decay counter (0..DECAY_PERIOD-1) that clears on every RAISE or LOWER tick.
REQ-023 SHALL increment the decay counter on a NEUTRAL tick; on the tick where it equals DECAY_PERIOD-1 it SHALL clear and move level by 1 toward RESET_LEVEL, leaving level unchanged if already equal.
REQ-024 SHALL implement the FSM as NORMAL->REFRACT on a tick that applies FAST_STEP, loading a refractory counter with REFRACT_TICKS-1.
REQ-025 SHALL, in REFRACT, decrement the refractory counter on every tick of any class and return to NORMAL on the tick where the counter is 0.
REQ-026 SHALL cause a saturating fast step (including one producing no change at a bound) to still enter REFRACT.
REQ-027 SHALL register q_changed high for exactly the cycle following an update edge whose new level[7:6] differs from the old.
REQ-028 SHALL derive at_min, at_max and level_q combinationally from the level register, so they have no extra latency.
REQ-029 SHALL make every update visible on level one cycle after the tick edge, with no combinational input-to-output path.

Reset
REQ-030 SHALL, while rst_n=0, asynchronously force level=RESET_LEVEL, decay counter=0, refractory counter=0, FSM=NORMAL and q_changed=0.
REQ-031 SHALL, on reset during REFRACT or mid-decay, discard all state, with the first tick after release behaving as in NORMAL.
REQ-032 SHALL recover synchronously on the first rising clk edge after rst_n rises.

Verification
REQ-033 SHALL cover reset: after reset, level=0x80, level_q=2, q_changed=0, refractory=0.
REQ-034 SHALL cover a fast raise with REFRACT: from 0x80, tick with inc=1, fast=1 -> level=0x88, refractory=1; then 4 further ticks with inc=1, fast=1 -> 0x89,0x8A,0x8B,0x8C and refractory=0 after the 4th.
REQ-035 SHALL cover saturation: from 0xFC, a fast raise -> level=0xFF, at_max=1; then a LOWER tick with fast=0 -> 0xFE.
REQ-036 SHALL cover the level_q boundary: from 0x80, a LOWER tick -> level=0x7F, level_q=1, and q_changed high for exactly 1 cycle.
REQ-037 SHALL cover decay: from 0x90 with inc=dec=1 for 16 ticks -> level=0x8F after the 16th only; from 0x80, 32 NEUTRAL ticks -> level stays 0x80.
REQ-038 SHALL cover tick gating: with tick=0 and inc=1, fast=1 for 10 cycles -> level and all counters unchanged.
